regfile_stream_loader: RTL and testbench

REGFILE_STREAM_LOADER -- requirements
Module: regfile_stream_loader

---
 rtl/regfile_stream_loader.sv | 124 ++++++++++++
 tb/tb_regfile_stream_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stream_loader.sv
// rtl/regfile_stream_loader.sv - byte stream to register-file word loader over an address window
// Optional running checksum: define REGFILE_STREAM_LOADER_CHECKSUM_EN.
module regfile_stream_loader #(
    parameter int addr_width = 1,
    parameter int data_width = 8,
    parameter int lo         = 0,
    parameter int hi         = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [addr_width-1:0] WR_ADDR,
    output logic [data_width-1:0] WR_DATA,
    output logic                  WR_EN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [7:0]            CHECKSUM
);

    localparam int BYTES = data_width / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECV   = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;

    logic w_accept;
    logic w_last;
    logic w_at_hi;
    logic w_start_ok;

    assign w_accept   = (r_state == S_RECV) && IN_VALID;
    assign w_last     = (r_cnt == CNT_W'(BYTES - 1));
    assign w_at_hi    = (r_addr == addr_width'(hi));
    assign w_start_ok = START && ((r_state == S_IDLE) || (r_state == S_FINISH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        IN_READY = 1'b0;
        WR_EN    = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) w_next = S_RECV;
            end
            S_RECV: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (w_accept && w_last) w_next = S_WRITE;
            end
            S_WRITE: begin
                WR_EN  = 1'b1;
                BUSY   = 1'b1;
                w_next = w_at_hi ? S_FINISH : S_RECV;
            end
            S_FINISH: begin
                DONE = 1'b1;
                if (START) w_next = S_RECV;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word assembly: byte k of a word lands in lane k (little-endian).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_start_ok) begin
            r_addr <= addr_width'(lo);
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < BYTES; k++) begin
                if (r_cnt == CNT_W'(k)) r_data[8*k +: 8] <= IN_DATA;
            end
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end else if (r_state == S_WRITE && !w_at_hi) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign WR_ADDR = r_addr;
    assign WR_DATA = r_data;

`ifdef REGFILE_STREAM_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge CLK) begin
        if (RST || w_start_ok) begin
            r_checksum <= 8'h00;
        end else if (w_accept) begin
            r_checksum <= r_checksum + IN_DATA;
        end
    end

    assign CHECKSUM = r_checksum;
`else
    assign CHECKSUM = 8'h00;
`endif

endmodule

// File: tb/tb_regfile_stream_loader.sv
// tb/tb_regfile_stream_loader.sv - scoreboard bench for regfile_stream_loader (4-bit addr, 32-bit data, window 2..5)
module tb_regfile_stream_loader;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LO = 2;
    localparam int HI = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [7:0]    IN_DATA = 8'h00;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          WR_EN;
    logic          BUSY;
    logic          DONE;
    logic [7:0]    CHECKSUM;

    regfile_stream_loader #(
        .addr_width(AW),
        .data_width(DW),
        .lo        (LO),
        .hi        (HI)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_EN    (WR_EN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CHECKSUM (CHECKSUM)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_word;
    int               m_pos;
    logic [7:0]       m_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cks(input logic [7:0] s);
`ifdef REGFILE_STREAM_LOADER_CHECKSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    always @(negedge CLK) begin
        if (!RST && WR_EN) begin
            logic [AW+DW-1:0] e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {WR_ADDR, WR_DATA}, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", WR_ADDR, e[AW+DW-1:DW]);
                check("wr_data", WR_DATA, e[DW-1:0]);
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; START = 1'b0; IN_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        m_pos = 0;
    endtask

    task automatic pulse_start();
        @(posedge CLK); #1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        m_addr = AW'(LO);
        m_pos  = 0;
        m_word = '0;
        m_sum  = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        for (int i = 0; i < gap; i++) @(posedge CLK);
        #1;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            n++;
        end while (!rdy && n < 50);
        #1;
        IN_VALID = 1'b0;
        if (!rdy) begin
            check("accept_timeout", 0, 1);
            return;
        end
        m_word[8*m_pos +: 8] = b;
        m_sum = m_sum + b;
        m_pos++;
        if (m_pos == DW / 8) begin
            exp_q.push_back({m_addr, m_word});
            m_addr = m_addr + 1'b1;
            m_pos  = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, IN_READY, 0);
        check({tag, "_wr_en"}, WR_EN, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_addr"}, WR_ADDR, 0);
        check({tag, "_data"}, WR_DATA, 0);
        check({tag, "_cks"}, CHECKSUM, 0);
    endtask

    initial begin
        int w0;
        m_addr = AW'(LO); m_word = '0; m_pos = 0; m_sum = 8'h00;

        do_reset();
        check_all_zero("reset");

        // single word, back-to-back bytes
        pulse_start();
        check("start_busy", BUSY, 1);
        check("start_ready", IN_READY, 1);
        w0 = wr_cnt;
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        @(negedge CLK);
        check("one_word_wr_en", WR_EN, 1);
        idle_cycles(3);
        check("one_word_count", wr_cnt - w0, 1);
        check("one_word_cks", CHECKSUM, exp_cks(8'hAA));

        // reset mid-word discards the partial word
        pulse_start();
        send_byte(8'hA1, 0); send_byte(8'hA2, 0);
        do_reset();
        check_all_zero("abort");
        idle_cycles(4);
        check("abort_no_wr", wr_cnt - w0, 1);
        pulse_start();
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        idle_cycles(3);

        // stalled stream: 3 idle cycles between bytes
        do_reset();
        pulse_start();
        w0 = wr_cnt;
        send_byte(8'h11, 3); send_byte(8'h22, 3); send_byte(8'h33, 3); send_byte(8'h44, 3);
        idle_cycles(6);
        check("stall_count", wr_cnt - w0, 1);

        // full window load: 16 bytes to addresses 2..5
        do_reset();
        pulse_start();
        w0 = wr_cnt;
        for (int i = 1; i <= 16; i++) send_byte(8'(i), 0);
        @(negedge CLK);
        check("full_last_wr_en", WR_EN, 1);
        @(negedge CLK);
        check("full_done", DONE, 1);
        check("full_ready", IN_READY, 0);
        check("full_busy", BUSY, 0);
        check("full_addr_hi", WR_ADDR, HI);
        check("full_cks", CHECKSUM, exp_cks(8'h88));
        check("full_cks_model", CHECKSUM, exp_cks(m_sum));
        idle_cycles(5);
        check("full_count", wr_cnt - w0, 4);
        check("finish_hold_done", DONE, 1);

        // restart from FINISH
        pulse_start();
        check("restart_done", DONE, 0);
        check("restart_busy", BUSY, 1);
        check("restart_addr", WR_ADDR, LO);
        check("restart_cks", CHECKSUM, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        idle_cycles(3);
        check("restart_cks_after", CHECKSUM, exp_cks(m_sum));

        // START during RECV is ignored
        do_reset();
        pulse_start();
        w0 = wr_cnt;
        send_byte(8'h50, 0);
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int i = 1; i < 16; i++) send_byte(8'h50 + 8'(i), (i % 3 == 0) ? 1 : 0);
        idle_cycles(4);
        check("ign_start_count", wr_cnt - w0, 4);
        check("ign_start_done", DONE, 1);
        check("ign_start_cks", CHECKSUM, exp_cks(m_sum));

        idle_cycles(3);
        check("queue_empty", exp_q.size(), 0);
        check("total_writes", wr_cnt, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
